// File: rtl/mbe_pkg.sv
// Shared types for the radix-4 Modified-Booth multipliers: controller states,
// Booth digit encoding and the 3-bit group decoder.
package mbe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mbe_state_t;

    typedef enum logic [2:0] {
        BZERO,
        BPOS1,
        BPOS2,
        BNEG1,
        BNEG2
    } booth_digit_t;

    // grp = {b[2i+1], b[2i], b[2i-1]}; digit = -2*grp[2] + grp[1] + grp[0]
    function automatic booth_digit_t booth_decode(input logic [2:0] grp);
        booth_digit_t d;
        case (grp)
            3'b001, 3'b010: d = BPOS1;
            3'b011:         d = BPOS2;
            3'b100:         d = BNEG2;
            3'b101, 3'b110: d = BNEG1;
            default:        d = BZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mbe_booth_encoder.sv
// Combinational radix-4 Booth recoder: one overlapping 3-bit multiplier group
// to a signed digit in {0, +1, +2, -1, -2}.
module mbe_booth_encoder
    import mbe_pkg::*;
(
    input  logic [2:0]   grp,
    output booth_digit_t digit
);

    always_comb begin
        digit = booth_decode(grp);
    end

endmodule

// File: rtl/mbe_seq_mult_ctrl.sv
// Iterative radix-4 Modified-Booth signed multiplier: one partial product per
// clock through a single 2N-bit adder, valid/ready on operands and result.
module mbe_seq_mult_ctrl
    import mbe_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   a,
    input  logic signed [N-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*N-1:0] product,
    output logic                  busy
);

    localparam int HALF = N / 2;
    localparam int CW   = $clog2(HALF) + 1;
    localparam int W    = 2 * N;
    localparam logic signed [W-1:0] ONE = W'(1);

    generate
        if ((N % 2) != 0 || N < 4) begin : g_bad_n
            $error("mbe_seq_mult_ctrl: N must be even and >= 4");
        end
    endgenerate

    mbe_state_t          state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [N:0]          rec_sr;
    logic signed [W-1:0] mcand;
    logic signed [W-1:0] acc;
    logic signed [W-1:0] pp;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] prod_q;
    booth_digit_t        digit;
    logic                accept;
    logic                last_iter;

    mbe_booth_encoder u_enc (
        .grp   (rec_sr[2:0]),
        .digit (digit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    assign accept    = in_valid && in_ready;
    assign last_iter = (state == RUN) && (cnt == CW'(HALF - 1));

    // mcand is pre-shifted by 2i, so the digit only selects +/-X or +/-2X
    always_comb begin
        case (digit)
            BPOS1:   pp = mcand;
            BPOS2:   pp = mcand <<< 1;
            BNEG1:   pp = ~mcand + ONE;
            BNEG2:   pp = ~(mcand <<< 1) + ONE;
            default: pp = '0;
        endcase
    end

    assign sum = acc + pp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            rec_sr <= '0;
            mcand  <= '0;
            acc    <= '0;
            prod_q <= '0;
        end else if (accept) begin
            cnt    <= '0;
            rec_sr <= {b, 1'b0};
            mcand  <= {{N{a[N-1]}}, a};
            acc    <= '0;
        end else if (state == RUN) begin
            acc    <= sum;
            mcand  <= mcand <<< 2;
            rec_sr <= {2'b00, rec_sr[N:2]};
            if (cnt != CW'(HALF)) begin
                cnt <= cnt + 1'b1;
            end
            if (last_iter) begin
                prod_q <= sum;
            end
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_mbe_seq_mult_ctrl.sv
// Bench for mbe_seq_mult_ctrl at N=8: cycle-level reference model plus
// directed vectors with hand-computed products.
module tb_mbe_seq_mult_ctrl;

    localparam int N    = 8;
    localparam int HALF = N / 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic [2*N-1:0]      product;
    logic                busy;

    int n_chk = 0;
    int n_err = 0;

    mbe_seq_mult_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: idle/waiting/result-ready view of one operation at a time
    int          eidx   = 0;
    int          m_due  = 0;
    bit          m_idle = 1'b1;
    bit          m_outv = 1'b0;
    logic [15:0] m_prod = '0;
    logic [15:0] m_exp  = '0;
    int          m_pr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle = 1'b1;
            m_outv = 1'b0;
            m_prod = '0;
        end else begin
            eidx++;
            if (m_idle) begin
                if (in_valid) begin
                    m_idle = 1'b0;
                    m_pr   = int'(a) * int'(b);
                    m_exp  = m_pr[15:0];
                    m_due  = eidx + HALF;
                end
            end else if (m_outv && out_ready) begin
                m_idle = 1'b1;
                m_outv = 1'b0;
            end
            if (!m_idle && !m_outv && eidx == m_due) begin
                m_outv = 1'b1;
                m_prod = m_exp;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_in_ready", 32'(in_ready), 32'(m_idle));
        chk("cyc_out_valid", 32'(out_valid), 32'(m_outv));
        chk("cyc_busy", 32'(busy), 32'(!m_idle));
        if (m_idle || m_outv) chk("cyc_product", 32'(product), 32'(m_prod));
    end

    // Caller is at posedge+1 with the DUT idle and out_ready=1
    task automatic run_op(input logic signed [N-1:0] aa, input logic signed [N-1:0] bb,
                          input logic [15:0] ex, input string nm);
        int gap;
        bit seen;
        in_valid = 1'b1;
        a = aa;
        b = bb;
        @(posedge clk);
        #1 in_valid = 1'b0;
        gap  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            gap++;
            if (out_valid) seen = 1'b1;
            else chk({nm, "_rdy_low"}, 32'(in_ready), 32'd0);
        end
        chk({nm, "_done"}, 32'(seen), 32'd1);
        chk({nm, "_gap"}, 32'(gap), 32'(HALF + 1));
        chk({nm, "_prod"}, 32'(product), 32'(ex));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk({nm, "_wait"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam int NC = 10;
    logic signed [N-1:0] corner [NC] = '{-8'sd128, -8'sd127, -8'sd86, -8'sd2, -8'sd1,
                                        8'sd0, 8'sd1, 8'sd2, 8'sd85, 8'sd127};

    initial begin
        logic signed [N-1:0] ra, rb;
        int pr;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        #11 rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(8'sd3, 8'sd5, 16'd15, "t1_3x5");
        run_op(-8'sd128, -8'sd128, 16'h4000, "t2_m128sq");
        run_op(-8'sd128, 8'sd127, 16'hC080, "t2_m128x127");
        run_op(-8'sd1, -8'sd1, 16'h0001, "t2_m1sq");
        run_op(8'sd0, -8'sd77, 16'h0000, "t2_zero");

        // Backpressure with a competing in_valid
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = -8'sd3;
        b = 8'sd9;
        @(posedge clk);
        #1 a = 8'sd11;
        b = 8'sd11;
        wait_valid("t3_first");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_prod", 32'(product), 32'h0000FFE5);
            chk("t3_no_accept", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("t3_after_hs_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid("t3_second");
        chk("t3_second_prod", 32'(product), 32'h00000079);
        @(posedge clk);
        #1;

        // Operands toggling during RUN are ignored
        in_valid = 1'b1;
        a = 8'sd25;
        b = -8'sd3;
        @(posedge clk);
        for (int i = 0; i < HALF; i++) begin
            #1 a = N'($urandom);
            b = N'($urandom);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_prod", 32'(product), 32'h0000FFB5);
        @(posedge clk);
        #1;

        // Asynchronous reset in iteration 2
        in_valid = 1'b1;
        a = 8'sd100;
        b = 8'sd100;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_product", 32'(product), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(8'sd7, -8'sd6, 16'hFFD6, "t5_7xm6");

        for (int i = 0; i < NC; i++) begin
            for (int j = 0; j < NC; j++) begin
                pr = int'(corner[i]) * int'(corner[j]);
                run_op(corner[i], corner[j], pr[15:0], "corner");
            end
        end

        for (int k = 0; k < 1500; k++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            pr = int'(ra) * int'(rb);
            run_op(ra, rb, pr[15:0], "rnd");
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
